mem_stage_dcache: RTL

//  Data-cache controller for the MEM stage; consumes MemReadOut/MemWriteOut/ALUResultOut/readDataTwoOut

---
 rtl/dcache_pkg.sv | 12 +
 rtl/dcache_line_store.sv | 35 +++
 rtl/mem_stage_dcache.sv | 94 +++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, derived widths and FSM encoding for the MEM-stage data cache
package dcache_pkg;
  localparam int INDEX_BITS = 4;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int WORDS = 1 << OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int INDEX_LSB = OFFSET_BITS + 2;
  localparam int TAG_LSB = INDEX_BITS + OFFSET_BITS + 2;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/tag/data arrays with one write port, async read, valid clear
module dcache_line_store
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_BITS-1:0]  rdIndex,
  input  logic [OFFSET_BITS-1:0] rdOffset,
  output logic                   rdValid,
  output logic [TAG_BITS-1:0]    rdTag,
  output logic [31:0]            rdWord,
  input  logic                   wrEn,
  input  logic [INDEX_BITS-1:0]  wrIndex,
  input  logic [OFFSET_BITS-1:0] wrOffset,
  input  logic [31:0]            wrData,
  input  logic                   tagEn,
  input  logic [TAG_BITS-1:0]    wrTag,
  input  logic                   invEn
);
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         words [LINES][WORDS];
  assign rdValid = valid[rdIndex];
  assign rdTag = tags[rdIndex];
  assign rdWord = words[rdIndex][rdOffset];
  always_ff @(posedge clk)
    if (!rst_n) valid <= '0;
    else if (tagEn) valid[wrIndex] <= 1'b1;
    else if (invEn) valid[wrIndex] <= 1'b0;
  // only valid bits are reset; tag and data contents are don't-care until revalidated
  always_ff @(posedge clk) begin
    if (wrEn) words[wrIndex][wrOffset] <= wrData;
    if (tagEn) tags[wrIndex] <= wrTag;
  end
endmodule

// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped write-through no-allocate MEM-stage data cache controller
// Optional DCACHE_STATS_EN adds stat_hits/stat_misses counters.
module mem_stage_dcache
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  state_t state, nextState;
  logic [OFFSET_BITS-1:0] count;
  logic [29:0] reqWord;
  logic [31:0] reqData;
  logic lineValid, lineHit, readHit, storeHit, refillAck, lastAck, missStart, unusedBits;
  logic [TAG_BITS-1:0] lineTag;
  logic [31:0] lineWord;
  assign unusedBits = ^addr[1:0];
  assign lineHit = lineValid && lineTag == addr[31:TAG_LSB];
  assign readHit = state == IDLE && MemRead && !MemWrite && lineHit;
  assign storeHit = state == IDLE && MemWrite && lineHit;
  assign refillAck = state == REFILL && mem_ack;
  assign lastAck = refillAck && count == LAST_WORD;
  assign missStart = state == IDLE && nextState == REFILL;
  // refill writes come from the latched request; store hits come straight from the pipeline
  dcache_line_store store (
    .clk(clk),
    .rst_n(rst_n),
    .rdIndex(addr[INDEX_LSB +: INDEX_BITS]),
    .rdOffset(addr[2 +: OFFSET_BITS]),
    .rdValid(lineValid),
    .rdTag(lineTag),
    .rdWord(lineWord),
    .wrEn(refillAck || storeHit),
    .wrIndex(state == REFILL ? reqWord[OFFSET_BITS +: INDEX_BITS] : addr[INDEX_LSB +: INDEX_BITS]),
    .wrOffset(state == REFILL ? count : addr[2 +: OFFSET_BITS]),
    .wrData(state == REFILL ? mem_rdata : writeData),
    .tagEn(lastAck),
    .wrTag(reqWord[29 -: TAG_BITS]),
    .invEn(missStart)
  );
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nextState;
  always_comb
    nextState = state == IDLE   ? (MemWrite ? WRITE : MemRead && !lineHit ? REFILL : IDLE) :
                state == REFILL ? (lastAck ? IDLE : REFILL) :
                state == WRITE  ? (mem_ack ? DONE : WRITE) : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= '0;
      reqWord <= '0;
      reqData <= '0;
    end else begin
      count <= refillAck ? count + 1'b1 : state == IDLE ? '0 : count;
      if (state == IDLE && (MemRead || MemWrite)) begin
        reqWord <= addr[31:2];
        reqData <= writeData;
      end
    end
  always_comb begin
    hit = state == IDLE ? (!MemRead && !MemWrite) || readHit : state == DONE;
    readData = readHit ? lineWord : '0;
    mem_req = state == REFILL || state == WRITE;
    mem_we = state == WRITE;
    mem_addr = state == REFILL ? {reqWord[29:OFFSET_BITS], count, 2'b00} :
               state == WRITE  ? {reqWord, 2'b00} : '0;
    mem_wdata = state == WRITE ? reqData : '0;
  end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else begin
      stat_hits <= stat_hits + 32'(readHit);
      stat_misses <= stat_misses + 32'(missStart);
    end
`endif
endmodule
